// File: rtl/apb_master.sv
// apb_master: single-outstanding APB requester.
// Takes one command at a time from a valid/ready port, runs an APB SETUP and
// ACCESS transfer for it, and returns a one-cycle response pulse.
// Optional feature macro: APB_MASTER_TIMEOUT_EN
//   When it is defined, a transfer is aborted once the slave has held pready_i
//   low for WAIT_LIMIT consecutive ACCESS edges. The abort response has
//   rsp_err_o = 1 and rsp_rdata_o = 0.
//   When it is undefined, ACCESS waits indefinitely, the wait counter does not
//   exist, and rsp_err_o is tied to 0.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | cmd_ready_o high; waiting for a command; APB bus deselected
// SETUP  | psel_o high, penable_o low; lasts exactly one cycle
// ACCESS | psel_o and penable_o high; waiting for pready_i (or a timeout)

`default_nettype none

module apb_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int WAIT_LIMIT = 16
) (
    input  logic                  pclk_i,
    input  logic                  prst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  psel_o,
    output logic                  penable_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic                  pwrite_o,
    output logic [DATA_WIDTH-1:0] pwdata_o,
    input  logic                  pready_i,
    input  logic [DATA_WIDTH-1:0] prdata_i
);

    // WAIT_LIMIT must fit the 8-bit wait counter; the check runs in both builds.
    if (WAIT_LIMIT < 1 || WAIT_LIMIT > 255) begin : g_bad_wait_limit
        $error("apb_master: WAIT_LIMIT must be in 1..255");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    state_e                state_q,     state_d;
    logic                  write_q,     write_d;
    logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,     wdata_d;
    logic                  psel_q,      psel_d;
    logic                  penable_q,   penable_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    // Asserted on an ACCESS edge where the slave is still stalling and the
    // wait budget has run out. Completion (pready_i high) always takes priority.
    logic timeout_hit;
    logic abort;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam logic [7:0] WaitLimitC = 8'(WAIT_LIMIT);

    logic [7:0] wait_cnt_q;
    logic       rsp_err_q;

    // Wait counter: cleared when a command enters SETUP, counts stalled ACCESS edges.
    always_ff @(posedge pclk_i) begin
        if (prst_i) begin
            wait_cnt_q <= 8'd0;
        end else if (state_d == ST_SETUP) begin
            wait_cnt_q <= 8'd0;
        end else if (state_q == ST_ACCESS && !pready_i) begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
        end
    end

    // The abort triggers on the edge where the count would reach WAIT_LIMIT.
    assign timeout_hit = ((wait_cnt_q + 8'd1) == WaitLimitC);

    // The error flag is a one-cycle pulse that is valid together with rsp_valid_o.
    always_ff @(posedge pclk_i) begin
        if (prst_i) begin
            rsp_err_q <= 1'b0;
        end else begin
            rsp_err_q <= abort;
        end
    end

    assign rsp_err_o = rsp_err_q;
`else
    assign timeout_hit = 1'b0;
    assign rsp_err_o   = 1'b0;
`endif

    assign abort = (state_q == ST_ACCESS) && !pready_i && timeout_hit;

    // Next-state, command latch and response logic.
    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    write_d = cmd_write_i;
                    addr_d  = cmd_addr_i;
                    // A read keeps pwdata_o at 0 for the whole transfer.
                    wdata_d = cmd_write_i ? cmd_wdata_i : '0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready_i) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = write_q ? '0 : prdata_i;
                end else if (abort) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // APB strobes are derived from the next state so that they come
        // straight from flops, with no combinational path from the inputs.
        psel_d    = (state_d != ST_IDLE);
        penable_d = (state_d == ST_ACCESS);
    end

    // State, latched command and registered outputs.
    always_ff @(posedge pclk_i) begin
        if (prst_i) begin
            state_q     <= ST_IDLE;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign cmd_ready_o = (state_q == ST_IDLE);
    assign psel_o      = psel_q;
    assign penable_o   = penable_q;
    assign paddr_o     = addr_q;
    assign pwrite_o    = write_q;
    assign pwdata_o    = wdata_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_master.sv
// Directed testbench for apb_master. Inputs are driven and outputs are sampled
// on the falling edge of the clock. Build with APB_MASTER_TIMEOUT_EN defined
// to also cover the abort path.

module tb_apb_master;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int WL    = 4;
    localparam int STALL = 3;   // the completion lands on the same edge as the limit
`else
    localparam int WL    = 16;
    localparam int STALL = 5;
`endif

    logic       clk = 1'b0;
    logic       prst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       psel;
    logic       penable;
    logic [7:0] paddr;
    logic       pwrite;
    logic [7:0] pwdata;
    logic       pready;
    logic [7:0] prdata;

    int tests_run    = 0;
    int tests_failed = 0;
    int ncyc;

    apb_master #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (8),
        .WAIT_LIMIT (WL)
    ) dut (
        .pclk_i      (clk),
        .prst_i      (prst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_write_i (cmd_write),
        .cmd_addr_i  (cmd_addr),
        .cmd_wdata_i (cmd_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .psel_o      (psel),
        .penable_o   (penable),
        .paddr_o     (paddr),
        .pwrite_o    (pwrite),
        .pwdata_o    (pwdata),
        .pready_i    (pready),
        .prdata_i    (prdata)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        prst      = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 8'h00;
        cmd_wdata = 8'h00;
        pready    = 1'b0;
        prdata    = 8'h00;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("rst_psel",      32'(psel),      32'd0);
        check_eq("rst_penable",   32'(penable),   32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_err",   32'(rsp_err),   32'd0);
        check_eq("rst_rsp_rdata", 32'(rsp_rdata), 32'h0);
        check_eq("rst_paddr",     32'(paddr),     32'h0);
        check_eq("rst_pwrite",    32'(pwrite),    32'd0);
        check_eq("rst_pwdata",    32'(pwdata),    32'h0);
        prst = 1'b0;

        // Write 0x37 to 0xA0, registered-ready slave (one wait state)
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'hA0; cmd_wdata = 8'h37;
        @(negedge clk);
        check_eq("wr_setup_psel",    32'(psel),      32'd1);
        check_eq("wr_setup_penable", 32'(penable),   32'd0);
        check_eq("wr_setup_paddr",   32'(paddr),     32'hA0);
        check_eq("wr_setup_pwdata",  32'(pwdata),    32'h37);
        check_eq("wr_setup_pwrite",  32'(pwrite),    32'd1);
        check_eq("wr_setup_ready",   32'(cmd_ready), 32'd0);
        cmd_valid = 1'b0;
        @(negedge clk);
        check_eq("wr_acc1_penable", 32'(penable),   32'd1);
        check_eq("wr_acc1_psel",    32'(psel),      32'd1);
        check_eq("wr_acc1_rsp",     32'(rsp_valid), 32'd0);
        @(negedge clk);
        check_eq("wr_acc2_penable", 32'(penable), 32'd1);
        check_eq("wr_acc2_paddr",   32'(paddr),   32'hA0);
        check_eq("wr_acc2_pwdata",  32'(pwdata),  32'h37);
        pready = 1'b1;
        @(negedge clk);
        check_eq("wr_rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("wr_rsp_err",   32'(rsp_err),   32'd0);
        check_eq("wr_rsp_rdata", 32'(rsp_rdata), 32'h0);
        check_eq("wr_rsp_psel",  32'(psel),      32'd0);
        check_eq("wr_rsp_pen",   32'(penable),   32'd0);
        check_eq("wr_rsp_ready", 32'(cmd_ready), 32'd1);
        pready = 1'b0;
        @(negedge clk);
        check_eq("wr_rsp_once", 32'(rsp_valid), 32'd0);

        // Read 0xA0, zero-wait slave returns 0x64; the stray wdata must not appear on pwdata
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'hA0; cmd_wdata = 8'h55;
        @(negedge clk);
        check_eq("rd_setup_pwrite", 32'(pwrite), 32'd0);
        check_eq("rd_setup_pwdata", 32'(pwdata), 32'h0);
        check_eq("rd_setup_paddr",  32'(paddr),  32'hA0);
        cmd_valid = 1'b0;
        @(negedge clk);
        check_eq("rd_acc_penable", 32'(penable), 32'd1);
        check_eq("rd_acc_pwdata",  32'(pwdata),  32'h0);
        pready = 1'b1; prdata = 8'h64;
        @(negedge clk);
        check_eq("rd_rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("rd_rsp_rdata", 32'(rsp_rdata), 32'h64);
        check_eq("rd_rsp_err",   32'(rsp_err),   32'd0);
        pready = 1'b0; prdata = 8'h00;
        @(negedge clk);
        check_eq("rd_rsp_once",  32'(rsp_valid), 32'd0);
        check_eq("rd_rdata_hold", 32'(rsp_rdata), 32'h64);

        // Back-to-back: write 0x10 to 0x11, then read 0x22 with cmd_valid held high
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h11; cmd_wdata = 8'h10; pready = 1'b1;
        @(negedge clk);
        check_eq("b2b_w_setup_psel", 32'(psel),    32'd1);
        check_eq("b2b_w_setup_pen",  32'(penable), 32'd0);
        check_eq("b2b_w_pwdata",     32'(pwdata),  32'h10);
        cmd_write = 1'b0; cmd_addr = 8'h22; cmd_wdata = 8'h00; prdata = 8'h5A;
        @(negedge clk);
        check_eq("b2b_w_acc_pen",   32'(penable),   32'd1);
        check_eq("b2b_w_acc_paddr", 32'(paddr),     32'h11);
        check_eq("b2b_w_acc_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check_eq("b2b_w_rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("b2b_w_rsp_rdata", 32'(rsp_rdata), 32'h0);
        check_eq("b2b_w_rsp_ready", 32'(cmd_ready), 32'd1);
        check_eq("b2b_w_rsp_psel",  32'(psel),      32'd0);
        @(negedge clk);
        check_eq("b2b_r_setup_psel",  32'(psel),      32'd1);
        check_eq("b2b_r_setup_pen",   32'(penable),   32'd0);
        check_eq("b2b_r_setup_paddr", 32'(paddr),     32'h22);
        check_eq("b2b_r_setup_pwr",   32'(pwrite),    32'd0);
        check_eq("b2b_r_setup_rsp",   32'(rsp_valid), 32'd0);
        cmd_valid = 1'b0;
        @(negedge clk);
        check_eq("b2b_r_acc_pen", 32'(penable), 32'd1);
        @(negedge clk);
        check_eq("b2b_r_rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("b2b_r_rsp_rdata", 32'(rsp_rdata), 32'h5A);
        pready = 1'b0; prdata = 8'h00;
        @(negedge clk);
        check_eq("b2b_r_rsp_once", 32'(rsp_valid), 32'd0);

        // Slave stalls for STALL cycles, then completes
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h33; cmd_wdata = 8'h44;
        @(negedge clk);
        check_eq("stall_setup_psel", 32'(psel), 32'd1);
        cmd_valid = 1'b0;
        ncyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!penable) break;
            ncyc++;
            check_eq("stall_paddr", 32'(paddr), 32'h33);
            check_eq("stall_no_rsp", 32'(rsp_valid), 32'd0);
            pready = (ncyc >= STALL + 1);
        end
        check_eq("stall_access_cycles", 32'(ncyc), 32'(STALL + 1));
        check_eq("stall_rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("stall_rsp_err",   32'(rsp_err),   32'd0);
        pready = 1'b0;
        @(negedge clk);
        check_eq("stall_rsp_once", 32'(rsp_valid), 32'd0);

`ifdef APB_MASTER_TIMEOUT_EN
        // Slave never ready: abort after WAIT_LIMIT ACCESS cycles
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h77; cmd_wdata = 8'h00;
        prdata = 8'hFF; pready = 1'b0;
        @(negedge clk);
        check_eq("to_setup_psel", 32'(psel), 32'd1);
        cmd_valid = 1'b0;
        ncyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!penable) break;
            ncyc++;
        end
        check_eq("to_access_cycles", 32'(ncyc),      32'd4);
        check_eq("to_rsp_valid",     32'(rsp_valid), 32'd1);
        check_eq("to_rsp_err",       32'(rsp_err),   32'd1);
        check_eq("to_rsp_rdata",     32'(rsp_rdata), 32'h0);
        check_eq("to_cmd_ready",     32'(cmd_ready), 32'd1);
        check_eq("to_psel",          32'(psel),      32'd0);
        prdata = 8'h00;
        @(negedge clk);
        check_eq("to_rsp_once", 32'(rsp_valid), 32'd0);
        check_eq("to_err_clear", 32'(rsp_err),  32'd0);
`endif

        // Reset during ACCESS; pready is high on the reset edge but no response may appear
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h5A; cmd_wdata = 8'hA5; pready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check_eq("rstmid_acc_pen", 32'(penable), 32'd1);
        prst = 1'b1; pready = 1'b1;
        @(negedge clk);
        check_eq("rstmid_psel",  32'(psel),      32'd0);
        check_eq("rstmid_pen",   32'(penable),   32'd0);
        check_eq("rstmid_ready", 32'(cmd_ready), 32'd1);
        check_eq("rstmid_rsp",   32'(rsp_valid), 32'd0);
        prst = 1'b0; pready = 1'b0;
        @(negedge clk);
        check_eq("rstmid_rsp_after", 32'(rsp_valid), 32'd0);
        check_eq("rstmid_psel_after", 32'(psel),     32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
